// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock with bit_valid and last, optionally followed by GAP idle cycles.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             a,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             a_n, bit_valid_n, last_n;
    logic             accept;

    // Handshake: a word transfers on a rising edge where load_valid and
    // load_ready are both high. load_ready depends only on registered state,
    // so with GAP=0 the next word is taken on the edge that retires the last bit.
    assign load_ready = (state == S_IDLE) ||
                        (state == S_SHIFT && cnt == CNT_LAST && GAP == 0);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            a         <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_cnt_n;
            a         <= a_n;
            bit_valid <= bit_valid_n;
            last      <= last_n;
            busy      <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        gap_cnt_n   = gap_cnt;
        a_n         = 1'b0;
        bit_valid_n = 1'b0;
        last_n      = 1'b0;

        case (state)
            S_SHIFT: begin
                if (cnt != CNT_LAST) begin
                    // shreg keeps the bit currently on a at its output end
                    cnt_n       = cnt + 1'b1;
                    shreg_n     = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};
                    a_n         = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
                    bit_valid_n = 1'b1;
                    last_n      = (cnt + 1'b1 == CNT_LAST);
                end else if (GAP > 0) begin
                    state_n   = S_GAP;
                    gap_cnt_n = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_IDLE;
                else                     gap_cnt_n = gap_cnt + 1'b1;
            end
            default: state_n = state;
        endcase

        // Accept only happens in IDLE or on the final SHIFT bit, so it overrides.
        if (accept) begin
            state_n     = S_SHIFT;
            shreg_n     = load_data;
            cnt_n       = '0;
            a_n         = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            bit_valid_n = 1'b1;
            last_n      = 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a default instance (MSB first, no gap) and a
// GAP=2 LSB-first instance, checked every cycle against a queue model.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic       lv, lv_g;
    logic [3:0] ld, ld_g;
    logic       lr, a, bv, last, busy;
    logic       lr_g, a_g, bv_g, last_g, busy_g;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(lr),
        .a(a), .bit_valid(bv), .last(last), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .load_valid(lv_g), .load_data(ld_g), .load_ready(lr_g),
        .a(a_g), .bit_valid(bv_g), .last(last_g), .busy(busy_g)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one entry per future output cycle, {bit_valid, last, a}.
    // The head is what the outputs show in the current cycle.
    logic [2:0] mq0[$];
    logic [2:0] mq1[$];
    logic [2:0] e0, e1;
    bit acc0, acc1;

    function automatic bit rdy0();
        return (mq0.size() == 0) || (mq0.size() == 1 && mq0[0][1]);
    endfunction

    function automatic bit rdy1();
        return (mq1.size() == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
        end else begin
            acc0 = lv && rdy0();
            acc1 = lv_g && rdy1();
            if (mq0.size() > 0) void'(mq0.pop_front());
            if (mq1.size() > 0) void'(mq1.pop_front());
            if (acc0)
                for (int k = 0; k < 4; k++) mq0.push_back({1'b1, (k == 3), ld[3-k]});
            if (acc1) begin
                for (int k = 0; k < 4; k++) mq1.push_back({1'b1, (k == 3), ld_g[k]});
                repeat (2) mq1.push_back(3'b000);
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            e0 = (mq0.size() > 0) ? mq0[0] : 3'b000;
            e1 = (mq1.size() > 0) ? mq1[0] : 3'b000;
            chk("m0_bit_valid", bv, e0[2]);
            chk("m0_last", last, e0[1]);
            chk("m0_a", a, e0[0]);
            chk("m0_busy", busy, mq0.size() > 0);
            chk("m0_load_ready", lr, rdy0());
            chk("m1_bit_valid", bv_g, e1[2]);
            chk("m1_last", last_g, e1[1]);
            chk("m1_a", a_g, e1[0]);
            chk("m1_busy", busy_g, mq1.size() > 0);
            chk("m1_load_ready", lr_g, rdy1());
        end
    end

    // Capture of emitted bits plus a shift-left register rebuilding the word.
    logic cap0[$], capl0[$], cap1[$], capl1[$];
    int   capi0[$];
    logic [3:0] sreg0;

    always @(negedge clk) begin
        if (bv) begin
            cap0.push_back(a);
            capl0.push_back(last);
            capi0.push_back(cyc);
            sreg0 = {sreg0[2:0], a};
        end
        if (bv_g) begin
            cap1.push_back(a_g);
            capl1.push_back(last_g);
        end
    end

    task automatic clr();
        cap0.delete(); capl0.delete(); capi0.delete();
        cap1.delete(); capl1.delete();
        sreg0 = 4'b0000;
    endtask

    // eb/el read left to right: entry i is compared with bit [n-1-i].
    task automatic chk_stream(input string name, input int sel, input int n,
                              input logic [7:0] eb, input logic [7:0] el);
        int sz;
        sz = (sel == 0) ? cap0.size() : cap1.size();
        chk({name, "_count"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            chk({name, "_bit"},  (sel == 0) ? cap0[i]  : cap1[i],  eb[n-1-i]);
            chk({name, "_last"}, (sel == 0) ? capl0[i] : capl1[i], el[n-1-i]);
        end
    endtask

    task automatic send0(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        lv = 1'b1;
        ld = d;
        while (!lr && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!lr) chk("send0_timeout", 0, 1);
        @(posedge clk);
        #1 lv = 1'b0;
    endtask

    task automatic send_g(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        lv_g = 1'b1;
        ld_g = d;
        while (!lr_g && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!lr_g) chk("send_g_timeout", 0, 1);
        @(posedge clk);
        #1 lv_g = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; lv = 1'b0; lv_g = 1'b0; ld = 4'h0; ld_g = 4'h0;
        sreg0 = 4'b0000;

        // Reset held three cycles: idle outputs, ready asserted
        @(posedge clk);
        #1 run = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_a", a, 0);
            chk("rst_bit_valid", bv, 0);
            chk("rst_last", last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_load_ready", lr, 1);
        end
        rst = 1'b0;

        // Single word MSB first
        #1 clr();
        send0(4'b1100);
        repeat (6) @(negedge clk);
        chk_stream("single", 0, 4, 8'b0000_1100, 8'b0000_0001);
        chk("single_rebuild", sreg0, 4'b1100);

        // Back-to-back with load_valid held
        #1 clr();
        @(negedge clk);
        lv = 1'b1;
        ld = 4'b1010;
        @(posedge clk);
        @(negedge clk);
        ld = 4'b0110;
        n = 0;
        while (!lr && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!lr) chk("b2b_timeout", 0, 1);
        @(posedge clk);
        #1 lv = 1'b0;
        repeat (8) @(negedge clk);
        chk_stream("b2b", 0, 8, 8'b1010_0110, 8'b0001_0001);
        if (capi0.size() == 8) chk("b2b_contiguous", capi0[7] - capi0[0], 7);

        // Load attempt while busy is ignored
        #1 clr();
        send0(4'b1001);
        @(negedge clk);
        @(posedge clk);
        #1 lv = 1'b1;
        ld = 4'b1111;
        @(negedge clk);
        chk("ignore_load_ready", lr, 0);
        @(posedge clk);
        #1 lv = 1'b0;
        repeat (6) @(negedge clk);
        chk_stream("ignore", 0, 4, 8'b0000_1001, 8'b0000_0001);

        // Async reset mid-word, then a fresh word
        #1 clr();
        send0(4'b1011);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_a", a, 0);
        chk("midrst_bit_valid", bv, 0);
        chk("midrst_last", last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_load_ready", lr, 1);
        chk_stream("pre_rst", 0, 2, 8'b0000_0010, 8'b0000_0000);
        @(negedge clk);
        rst = 1'b0;
        #1 clr();
        send0(4'b0101);
        repeat (6) @(negedge clk);
        chk_stream("post_rst", 0, 4, 8'b0000_0101, 8'b0000_0001);
        chk("post_rst_rebuild", sreg0, 4'b0101);

        // GAP=2, LSB first
        #1 clr();
        send_g(4'b0011);
        repeat (4) @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("gap_load_ready", lr_g, 0);
            chk("gap_bit_valid", bv_g, 0);
            chk("gap_busy", busy_g, 1);
        end
        @(negedge clk);
        chk("gap_end_load_ready", lr_g, 1);
        chk("gap_end_busy", busy_g, 0);
        chk_stream("gap", 1, 4, 8'b0000_1100, 8'b0000_0001);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
